status_reg_stack: RTL and testbench

STATUS_REG_STACK -- requirements
Module: status_reg_stack

---
 rtl/status_reg_stack.sv | 133 +++++++++++++
 tb/tb_status_reg_stack.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/status_reg_stack.sv
// Status flag register with a shadow save stack for interrupt entry/return.
//
// The flags are written from either the ALU or the decoder under a per-bit mask.
// A push saves the current flags into the next free shadow slot. A pop restores
// the flags from the most recent slot. A push to a full stack and a pop from an
// empty stack are both ignored, and the stack level never wraps.
//
// Optional feature: define STATUS_STACK_ERR_EN to get the sticky overflow and
// underflow flags (ovf_err / unf_err) and their clear input err_clr. With the
// macro undefined, both flags read 0 and err_clr has no effect.
module status_reg_stack #(
  parameter int unsigned NumStatusBits = 4,
  parameter int unsigned StackDepth    = 4,
  localparam int unsigned LvlW         = $clog2(StackDepth + 1)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     wr_en,
  input  logic                     sel_stat_in_alu_decoder,
  input  logic [NumStatusBits-1:0] alu_status,
  input  logic [NumStatusBits-1:0] dec_status,
  input  logic [NumStatusBits-1:0] wr_mask,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     err_clr,
  output logic [NumStatusBits-1:0] status,
  output logic [LvlW-1:0]          stack_level,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     ovf_err,
  output logic                     unf_err
);

  // The slot index needs at least one bit, even when there is a single slot.
  localparam int unsigned IdxW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

  logic [NumStatusBits-1:0] status_q, status_d;
  logic [LvlW-1:0]          level_q, level_d;
  logic [NumStatusBits-1:0] slots_q [StackDepth];

  logic [NumStatusBits-1:0] src;
  logic                     full, empty;
  logic                     push_eff, pop_eff;
  logic [LvlW-1:0]          level_m1;
  logic [IdxW-1:0]          push_idx, pop_idx;

  assign full  = (level_q == LvlW'(StackDepth));
  assign empty = (level_q == '0);

  // push and pop together cancel out. Both are also dropped at the stack limits.
  assign push_eff = push & ~pop & ~full;
  assign pop_eff  = pop & ~push & ~empty;

  assign level_m1 = level_q - LvlW'(1);
  assign push_idx = level_q[IdxW-1:0];
  assign pop_idx  = level_m1[IdxW-1:0];

  // Next flag and level values. A restore from the stack overrides any write.
  always_comb begin
    src      = sel_stat_in_alu_decoder ? alu_status : dec_status;
    status_d = status_q;
    level_d  = level_q;
    if (pop_eff) begin
      status_d = slots_q[pop_idx];
    end else if (wr_en) begin
      status_d = (status_q & ~wr_mask) | (src & wr_mask);
    end
    if (push_eff) begin
      level_d = level_q + LvlW'(1);
    end else if (pop_eff) begin
      level_d = level_m1;
    end
  end

  // Flag register and stack level. Reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (res) begin
      status_q <= '0;
      level_q  <= '0;
    end else begin
      status_q <= status_d;
      level_q  <= level_d;
    end
  end

  // The shadow slots are not reset. Each one captures the flags as they were before the edge.
  always_ff @(posedge clk) begin
    if (!res && push_eff) begin
      slots_q[push_idx] <= status_q;
    end
  end

`ifdef STATUS_STACK_ERR_EN
  logic ovf_q, unf_q;
  logic ovf_set, unf_set;

  assign ovf_set = push & ~pop & full;
  assign unf_set = pop & ~push & empty;

  // Sticky error flags. A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (res) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (err_clr) begin
        ovf_q <= 1'b0;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end else if (err_clr) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf_err        = 1'b0;
  assign unf_err        = 1'b0;
`endif

  assign status      = status_q;
  assign stack_level = level_q;
  assign stack_full  = full;
  assign stack_empty = empty;

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed testbench for status_reg_stack with its default parameters.
// The expected error flags follow STATUS_STACK_ERR_EN.
module tb_status_reg_stack;

`ifdef STATUS_STACK_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk;
  logic       res;
  logic       wr_en;
  logic       sel_stat_in_alu_decoder;
  logic [3:0] alu_status;
  logic [3:0] dec_status;
  logic [3:0] wr_mask;
  logic       push;
  logic       pop;
  logic       err_clr;
  logic [3:0] status;
  logic [2:0] stack_level;
  logic       stack_full;
  logic       stack_empty;
  logic       ovf_err;
  logic       unf_err;

  int n_cmp = 0;
  int n_err = 0;

  status_reg_stack dut (
    .clk                     (clk),
    .res                     (res),
    .wr_en                   (wr_en),
    .sel_stat_in_alu_decoder (sel_stat_in_alu_decoder),
    .alu_status              (alu_status),
    .dec_status              (dec_status),
    .wr_mask                 (wr_mask),
    .push                    (push),
    .pop                     (pop),
    .err_clr                 (err_clr),
    .status                  (status),
    .stack_level             (stack_level),
    .stack_full              (stack_full),
    .stack_empty             (stack_empty),
    .ovf_err                 (ovf_err),
    .unf_err                 (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the driven inputs across one rising edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res = 1'b0; wr_en = 1'b0; sel_stat_in_alu_decoder = 1'b0;
    alu_status = 4'h0; dec_status = 4'h0; wr_mask = 4'h0;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic dec_write(input logic [3:0] v);
    wr_en = 1'b1; sel_stat_in_alu_decoder = 1'b0; dec_status = v; wr_mask = 4'hf;
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic [2:0] lvl,
                           input logic ovf, input logic unf);
    check_eq({tag, ".status"}, 32'(status), 32'(st));
    check_eq({tag, ".level"}, 32'(stack_level), 32'(lvl));
    check_eq({tag, ".full"}, 32'(stack_full), 32'(lvl == 3'd4));
    check_eq({tag, ".empty"}, 32'(stack_empty), 32'(lvl == 3'd0));
    check_eq({tag, ".ovf"}, 32'(ovf_err), 32'(ovf));
    check_eq({tag, ".unf"}, 32'(unf_err), 32'(unf));
  endtask

  initial begin
    idle();
    res = 1'b1;
    step();
    step();
    idle();
    check_all("reset", 4'h0, 3'd0, 1'b0, 1'b0);

    // Masked write from the ALU, then hold when wr_en is low.
    dec_write(4'b1010);
    step();
    check_eq("wr_dec", 32'(status), 32'(4'b1010));
    idle();
    wr_en = 1'b1; sel_stat_in_alu_decoder = 1'b1;
    alu_status = 4'b0101; dec_status = 4'b1111; wr_mask = 4'b0011;
    step();
    check_eq("wr_masked", 32'(status), 32'(4'b1001));
    idle();
    alu_status = 4'b1111; wr_mask = 4'b1111;
    step();
    check_eq("hold", 32'(status), 32'(4'b1001));

    // Save and restore. The pop also ignores a concurrent write.
    dec_write(4'b0110);
    step();
    idle();
    push = 1'b1;
    dec_write(4'b1111);
    step();
    idle();
    check_all("push_wr", 4'b1111, 3'd1, 1'b0, 1'b0);
    pop = 1'b1;
    dec_write(4'b0000);
    step();
    idle();
    check_all("pop", 4'b0110, 3'd0, 1'b0, 1'b0);

    // Underflow with a write. Then clear the error.
    pop = 1'b1; wr_en = 1'b1; sel_stat_in_alu_decoder = 1'b1;
    alu_status = 4'b0001; wr_mask = 4'b1111;
    step();
    idle();
    check_all("underflow", 4'b0001, 3'd0, 1'b0, ErrEn);
    err_clr = 1'b1;
    step();
    idle();
    check_eq("unf_clr", 32'(unf_err), 32'(1'b0));

    // Five pushes, each with a write: slots get 1, 2, 3, 4, and the fifth push overflows.
    for (int i = 0; i < 5; i++) begin
      push = 1'b1;
      dec_write(4'(i + 2));
      step();
    end
    idle();
    check_all("overflow", 4'd6, 3'd4, ErrEn, 1'b0);

    // A new overflow together with err_clr leaves the flag set. err_clr alone clears it.
    push = 1'b1; err_clr = 1'b1;
    step();
    idle();
    check_all("ovf_vs_clr", 4'd6, 3'd4, ErrEn, 1'b0);
    err_clr = 1'b1;
    step();
    idle();
    check_eq("ovf_clr", 32'(ovf_err), 32'(1'b0));

    pop = 1'b1;
    step();
    check_all("pop4", 4'd4, 3'd3, 1'b0, 1'b0);
    step();
    idle();
    check_all("pop3", 4'd3, 3'd2, 1'b0, 1'b0);

    // push and pop together at level 2: no stack operation.
    push = 1'b1; pop = 1'b1;
    step();
    check_all("pp_nowr", 4'd3, 3'd2, 1'b0, 1'b0);
    dec_write(4'b1110);
    step();
    idle();
    check_all("pp_wr", 4'b1110, 3'd2, 1'b0, 1'b0);

    pop = 1'b1;
    step();
    check_all("pop2", 4'd2, 3'd1, 1'b0, 1'b0);
    step();
    idle();
    check_all("pop1", 4'd1, 3'd0, 1'b0, 1'b0);

    // Reset in the middle of operation, with errors pending and a push present.
    pop = 1'b1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1;
      dec_write(4'(i + 9));
      step();
    end
    idle();
    check_all("pre_reset", 4'd11, 3'd3, 1'b0, ErrEn);
    res = 1'b1; push = 1'b1;
    dec_write(4'hf);
    step();
    idle();
    check_all("mid_reset", 4'h0, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
